smg_disp_ctrl: RTL and testbench

Display controller that sits between the game logic and the 7-segment decoders and decides what the HEX digits show.
- Converts snake_length from binary to 3-digit decimal with a sequential shift-add-3 (double-dabble) engine.
- Temporarily overlays the last IR command code (hex) after each IR reception.
- Blinks the display while the game-over condition is asserted.
- Outputs feed one hex-to-7-segment decoder instance per digit; each digit's blank flag gates that decoder's output.

---
 rtl/smg_pkg.sv | 39 +++
 rtl/smg_bin2bcd.sv | 84 ++++++++
 rtl/smg_disp_ctrl.sv | 132 +++++++++++++
 tb/tb_smg_disp_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared definitions for the snake-game 7-segment display controller.
package smg_pkg;

    localparam int unsigned NumDigits = 3;

    // Per-digit blank patterns, bit i blanks digit i
    localparam logic [NumDigits-1:0] BlankAllOff = 3'b111;
    localparam logic [NumDigits-1:0] BlankIrView = 3'b100;
    localparam logic [NumDigits-1:0] BlankZero   = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } conv_state_e;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    function automatic logic [11:0] dd_adjust(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < NumDigits; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Leading-zero blanking for a 3-digit BCD value; units always lit
    function automatic logic [NumDigits-1:0] lead_blank(input logic [11:0] v);
        logic [NumDigits-1:0] r;
        r    = '0;
        r[2] = (v[11:8] == 4'd0);
        r[1] = (v[11:4] == 8'd0);
        return r;
    endfunction

endpackage

// File: rtl/smg_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, one bit per cycle).
// done pulses in the final shift cycle; bcd carries the finished result during that cycle.
module smg_bin2bcd
    import smg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        load,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_e state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [11:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [11:0] shifted;

    // Next-state logic for the conversion FSM and datapath
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        done    = 1'b0;
        shifted = {dd_adjust(acc_q)[10:0], sr_q[7]};
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load    = 1'b1;
                sr_d    = din;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                acc_d = shifted;
                sr_d  = {sr_q[6:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    done    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StLoad) || (state_d == StShift);
    end

    assign bcd  = shifted;
    assign busy = busy_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/smg_disp_ctrl.sv
// Chooses what the three HEX digits show: decimal snake length, IR code overlay, blink.
module smg_disp_ctrl
    import smg_pkg::*;
#(
    parameter int unsigned IR_HOLD_CYC = 50_000_000,
    parameter int unsigned BLINK_CYC   = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           snake_length,
    input  logic                 ir_valid,
    input  logic [7:0]           ir_data,
    input  logic                 game_over,
    output logic [3:0]           hex_in0,
    output logic [3:0]           hex_in1,
    output logic [3:0]           hex_in2,
    output logic [NumDigits-1:0] blank,
    output logic                 busy
);

    localparam int unsigned HoldW  = (IR_HOLD_CYC > 1) ? $clog2(IR_HOLD_CYC) : 1;
    localparam int unsigned BlinkW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic [7:0]           last_len_q;
    logic [11:0]          dec_q, dec_d;
    logic [7:0]           ir_q, ir_d;
    logic                 ovl_q, ovl_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [BlinkW-1:0]    blink_q, blink_d;
    logic                 phase_q, phase_d;
    logic [3:0]           h0_d, h1_d, h2_d;
    logic [NumDigits-1:0] bl_d;
    logic                 start, eng_load, eng_done;
    logic [11:0]          eng_bcd;

    // Reconvert whenever the length differs from the last captured operand
    assign start = (snake_length != last_len_q);

    smg_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (snake_length),
        .busy  (busy),
        .load  (eng_load),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    // Decimal result and IR overlay hold timer
    always_comb begin
        dec_d  = eng_done ? eng_bcd : dec_q;
        ir_d   = ir_q;
        ovl_d  = ovl_q;
        hold_d = hold_q;
        if (ir_valid) begin
            ir_d   = ir_data;
            ovl_d  = 1'b1;
            hold_d = HoldW'(IR_HOLD_CYC - 1);
        end else if (ovl_q) begin
            if (hold_q == '0) begin
                ovl_d = 1'b0;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    // Blink phase; leaving game-over snaps straight back to the on phase
    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        if (!game_over) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (blink_q == BlinkW'(BLINK_CYC - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + 1'b1;
        end
    end

    // Output mux built from next-state values so registered outputs track sources same-edge
    always_comb begin
        h2_d = dec_d[11:8];
        h1_d = dec_d[7:4];
        h0_d = dec_d[3:0];
        bl_d = lead_blank(dec_d);
        if (ovl_d) begin
            h2_d = 4'd0;
            h1_d = ir_d[7:4];
            h0_d = ir_d[3:0];
            bl_d = BlankIrView;
        end
        if (!phase_d) begin
            bl_d = BlankAllOff;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_len_q <= '0;
            dec_q      <= '0;
            ir_q       <= '0;
            ovl_q      <= 1'b0;
            hold_q     <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b1;
            hex_in0    <= 4'd0;
            hex_in1    <= 4'd0;
            hex_in2    <= 4'd0;
            blank      <= BlankZero;
        end else begin
            if (eng_load) begin
                last_len_q <= snake_length;
            end
            dec_q   <= dec_d;
            ir_q    <= ir_d;
            ovl_q   <= ovl_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            hex_in0 <= h0_d;
            hex_in1 <= h1_d;
            hex_in2 <= h2_d;
            blank   <= bl_d;
        end
    end

endmodule

// File: tb/tb_smg_disp_ctrl.sv
// Directed self-checking bench for smg_disp_ctrl (IR hold 20 cycles, blink half-period 4).
module tb_smg_disp_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] snake_length;
    logic       ir_valid;
    logic [7:0] ir_data;
    logic       game_over;
    logic [3:0] hex_in0, hex_in1, hex_in2;
    logic [2:0] blank;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    smg_disp_ctrl #(
        .IR_HOLD_CYC (20),
        .BLINK_CYC   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snake_length (snake_length),
        .ir_valid     (ir_valid),
        .ir_data      (ir_data),
        .game_over    (game_over),
        .hex_in0      (hex_in0),
        .hex_in1      (hex_in1),
        .hex_in2      (hex_in2),
        .blank        (blank),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves us 1 time unit past the rising edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_disp(input string tag, input logic [3:0] h2, input logic [3:0] h1,
                              input logic [3:0] h0, input logic [2:0] bl);
        check_eq({tag, "_h2"}, 16'(hex_in2), 16'(h2));
        check_eq({tag, "_h1"}, 16'(hex_in1), 16'(h1));
        check_eq({tag, "_h0"}, 16'(hex_in0), 16'(h0));
        check_eq({tag, "_blank"}, 16'(blank), 16'(bl));
    endtask

    task automatic conv(input string tag, input logic [7:0] len, input logic [3:0] h2,
                        input logic [3:0] h1, input logic [3:0] h0, input logic [2:0] bl);
        snake_length = len;
        tick(10);
        check_disp(tag, h2, h1, h0, bl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [3:0] e2, e1, e0;

        rst_n        = 1'b0;
        snake_length = 8'd0;
        ir_valid     = 1'b0;
        ir_data      = 8'd0;
        game_over    = 1'b0;
        tick(3);
        check_disp("reset", 4'd0, 4'd0, 4'd0, 3'b110);
        check_eq("reset_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: 123 -> 1/2/3 ten clocks later, busy for LOAD + 8 SHIFT
        snake_length = 8'd123;
        busy_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (i == 9) check_disp("t1_pre", 4'd0, 4'd0, 4'd0, 3'b110);
        end
        check_disp("t1_123", 4'd1, 4'd2, 4'd3, 3'b000);
        check_eq("t1_busy_cycles", 16'(busy_cnt), 16'd9);
        check_eq("t1_busy_done", 16'(busy), 16'd0);
        tick(2);

        // 2: leading-zero blanking patterns
        conv("t2_7", 8'd7, 4'd0, 4'd0, 4'd7, 3'b110);
        tick();
        conv("t2_255", 8'd255, 4'd2, 4'd5, 4'd5, 3'b000);
        tick();
        conv("t2_40", 8'd40, 4'd0, 4'd4, 4'd0, 3'b100);
        tick(2);

        // 3: IR overlay, 20-cycle hold, then hold restart by a second pulse
        ir_valid = 1'b1;
        ir_data  = 8'hA5;
        tick();
        ir_valid = 1'b0;
        check_disp("t3_a5", 4'd0, 4'hA, 4'h5, 3'b100);
        tick(19);
        check_disp("t3_a5_last", 4'd0, 4'hA, 4'h5, 3'b100);
        tick();
        check_disp("t3_dec_back", 4'd0, 4'd4, 4'd0, 3'b100);
        tick(2);
        ir_valid = 1'b1;
        ir_data  = 8'hA5;
        tick();
        ir_valid = 1'b0;
        tick(9);
        check_disp("t3_a5_c10", 4'd0, 4'hA, 4'h5, 3'b100);
        ir_valid = 1'b1;
        ir_data  = 8'h3C;
        tick();
        ir_valid = 1'b0;
        check_disp("t3_3c", 4'd0, 4'h3, 4'hC, 3'b100);
        tick(19);
        check_disp("t3_3c_last", 4'd0, 4'h3, 4'hC, 3'b100);
        tick();
        check_disp("t3_dec_back2", 4'd0, 4'd4, 4'd0, 3'b100);
        tick(2);

        // 4: 40 -> 12, then 99 during the 3rd SHIFT cycle; only 40, 12, 99 may appear
        snake_length = 8'd12;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (t == 4) snake_length = 8'd99;
            if (t < 10) begin
                e2 = 4'd0; e1 = 4'd4; e0 = 4'd0;
            end else if (t < 21) begin
                e2 = 4'd0; e1 = 4'd1; e0 = 4'd2;
            end else begin
                e2 = 4'd0; e1 = 4'd9; e0 = 4'd9;
            end
            check_disp($sformatf("t4_c%0d", t), e2, e1, e0, 3'b100);
        end
        tick(2);

        // 5: blink with length 50, then overlay while blinking
        conv("t5_50", 8'd50, 4'd0, 4'd5, 4'd0, 3'b100);
        tick();
        game_over = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check_eq($sformatf("t5_blink_c%0d", t), 16'(blank),
                     16'((((t / 4) % 2) == 1) ? 3'b111 : 3'b100));
        end
        game_over = 1'b0;
        tick();
        check_eq("t5_go_fall", 16'(blank), 16'(3'b100));
        tick();
        check_eq("t5_go_steady", 16'(blank), 16'(3'b100));
        game_over = 1'b1;
        ir_valid  = 1'b1;
        ir_data   = 8'h5A;
        tick();
        ir_valid = 1'b0;
        check_disp("t5_ir_on", 4'd0, 4'h5, 4'hA, 3'b100);
        tick(3);
        check_eq("t5_ir_off", 16'(blank), 16'(3'b111));
        tick(4);
        check_disp("t5_ir_on2", 4'd0, 4'h5, 4'hA, 3'b100);
        game_over = 1'b0;

        // 6: async reset mid-SHIFT and mid-overlay, then reconversion
        snake_length = 8'd200;
        ir_valid     = 1'b1;
        ir_data      = 8'h77;
        tick();
        ir_valid = 1'b0;
        tick(3);
        check_disp("t6_pre", 4'd0, 4'h7, 4'h7, 3'b100);
        check_eq("t6_pre_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        check_disp("t6_rst", 4'd0, 4'd0, 4'd0, 3'b110);
        check_eq("t6_rst_busy", 16'(busy), 16'd0);
        tick(2);
        rst_n = 1'b1;
        tick(9);
        check_disp("t6_pre_conv", 4'd0, 4'd0, 4'd0, 3'b110);
        check_eq("t6_busy_conv", 16'(busy), 16'd1);
        tick();
        check_disp("t6_200", 4'd2, 4'd0, 4'd0, 3'b000);
        check_eq("t6_busy_end", 16'(busy), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
